// File: rtl/pipe_stage_elastic.sv
// rtl/pipe_stage_elastic.sv - elastic pipeline stage with bubble-zeroed control field and optional skid entry
module pipe_stage_elastic #(
    parameter int CTRL_W = 5,
    parameter int DATA_W = 32,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    generate
        if (SKID == 0) begin : g_single
            logic              valid_q;
            logic [CTRL_W-1:0] ctrl_q;
            logic [DATA_W-1:0] data_q;
            logic              accept;
            logic              issue;

            assign in_ready = ~valid_q | out_ready;
            assign accept   = in_valid & in_ready;
            assign issue    = valid_q & out_ready;

            always_ff @(posedge clk) begin
                if (reset || flush) begin
                    valid_q <= 1'b0;
                end else if (accept) begin
                    valid_q <= 1'b1;
                end else if (issue) begin
                    valid_q <= 1'b0;
                end
            end

            // Payload is never reset; a flushed load is harmless because valid stays low.
            always_ff @(posedge clk) begin
                if (accept) begin
                    ctrl_q <= in_ctrl;
                    data_q <= in_data;
                end
            end

            assign out_valid = valid_q;
            assign out_ctrl  = ctrl_q & {CTRL_W{valid_q}};
            assign out_data  = data_q;
            assign occupancy = {1'b0, valid_q};
        end else begin : g_skid
            typedef enum logic [1:0] {
                EMPTY = 2'd0,
                ONE   = 2'd1,
                TWO   = 2'd2
            } state_e;

            state_e            state_q;
            logic              in_ready_q;
            logic [CTRL_W-1:0] main_ctrl_q;
            logic [DATA_W-1:0] main_data_q;
            logic [CTRL_W-1:0] skid_ctrl_q;
            logic [DATA_W-1:0] skid_data_q;
            logic              accept;
            logic              issue;

            assign accept = in_valid & in_ready_q;
            assign issue  = (state_q != EMPTY) & out_ready;

            // in_ready_q mirrors (next state != TWO) so it never depends on out_ready combinationally.
            always_ff @(posedge clk) begin
                if (reset || flush) begin
                    state_q    <= EMPTY;
                    in_ready_q <= 1'b1;
                end else begin
                    case (state_q)
                        EMPTY: begin
                            if (accept) begin
                                main_ctrl_q <= in_ctrl;
                                main_data_q <= in_data;
                                state_q     <= ONE;
                            end
                        end
                        ONE: begin
                            if (accept && !issue) begin
                                skid_ctrl_q <= in_ctrl;
                                skid_data_q <= in_data;
                                state_q     <= TWO;
                                in_ready_q  <= 1'b0;
                            end else if (accept && issue) begin
                                main_ctrl_q <= in_ctrl;
                                main_data_q <= in_data;
                            end else if (issue) begin
                                state_q <= EMPTY;
                            end
                        end
                        TWO: begin
                            if (issue) begin
                                main_ctrl_q <= skid_ctrl_q;
                                main_data_q <= skid_data_q;
                                state_q     <= ONE;
                                in_ready_q  <= 1'b1;
                            end
                        end
                        default: begin
                            state_q    <= EMPTY;
                            in_ready_q <= 1'b1;
                        end
                    endcase
                end
            end

            assign in_ready  = in_ready_q;
            assign out_valid = (state_q != EMPTY);
            assign out_ctrl  = main_ctrl_q & {CTRL_W{out_valid}};
            assign out_data  = main_data_q;
            assign occupancy = state_q;
        end
    endgenerate

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// tb/tb_pipe_stage_elastic.sv - scoreboard bench for pipe_stage_elastic in skid and single-register modes
module tb_pipe_stage_elastic;
    localparam int CW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;

    logic          in_valid1, in_ready1, out_valid1, out_ready1;
    logic [CW-1:0] in_ctrl1, out_ctrl1;
    logic [DW-1:0] in_data1, out_data1;
    logic [1:0]    occ1;

    logic          in_valid0, in_ready0, out_valid0, out_ready0;
    logic [CW-1:0] in_ctrl0, out_ctrl0;
    logic [DW-1:0] in_data0, out_data0;
    logic [1:0]    occ0;

    int checks = 0;
    int errors = 0;
    logic [CW+DW-1:0] sb1[$];
    logic [CW+DW-1:0] sb0[$];

    always #5 clk = ~clk;

    pipe_stage_elastic #(.CTRL_W(CW), .DATA_W(DW), .SKID(1)) dut1 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_ctrl(in_ctrl1), .in_data(in_data1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_ctrl(out_ctrl1), .out_data(out_data1),
        .occupancy(occ1)
    );

    pipe_stage_elastic #(.CTRL_W(CW), .DATA_W(DW), .SKID(0)) dut0 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid0), .in_ready(in_ready0), .in_ctrl(in_ctrl0), .in_data(in_data0),
        .out_valid(out_valid0), .out_ready(out_ready0), .out_ctrl(out_ctrl0), .out_data(out_data0),
        .occupancy(occ0)
    );

    // Called with inputs settled, between edges: scores the handshakes of the coming edge.
    task automatic step();
        logic [CW+DW-1:0] exp;
        if (out_valid1 === 1'b1 && out_ready1) begin
            checks++;
            if (sb1.size() == 0) begin
                errors++;
                $display("FAIL skid_unexpected_beat got ctrl=%0h data=%0d expected none", out_ctrl1, out_data1);
            end else begin
                exp = sb1.pop_front();
                if ({out_ctrl1, out_data1} !== exp) begin
                    errors++;
                    $display("FAIL skid_beat got ctrl=%0h data=%0d expected ctrl=%0h data=%0d",
                             out_ctrl1, out_data1, exp[DW+:CW], exp[DW-1:0]);
                end
            end
        end
        if (out_valid1 === 1'b0) begin
            checks++;
            if (out_ctrl1 !== '0) begin
                errors++;
                $display("FAIL skid_bubble_ctrl got %0h expected 0", out_ctrl1);
            end
        end
        if (reset || flush) sb1.delete();
        else if (in_valid1 && in_ready1) sb1.push_back({in_ctrl1, in_data1});

        if (out_valid0 === 1'b1 && out_ready0) begin
            checks++;
            if (sb0.size() == 0) begin
                errors++;
                $display("FAIL single_unexpected_beat got ctrl=%0h data=%0d expected none", out_ctrl0, out_data0);
            end else begin
                exp = sb0.pop_front();
                if ({out_ctrl0, out_data0} !== exp) begin
                    errors++;
                    $display("FAIL single_beat got ctrl=%0h data=%0d expected ctrl=%0h data=%0d",
                             out_ctrl0, out_data0, exp[DW+:CW], exp[DW-1:0]);
                end
            end
        end
        if (out_valid0 === 1'b0) begin
            checks++;
            if (out_ctrl0 !== '0) begin
                errors++;
                $display("FAIL single_bubble_ctrl got %0h expected 0", out_ctrl0);
            end
        end
        if (reset || flush) sb0.delete();
        else if (in_valid0 && in_ready0) sb0.push_back({in_ctrl0, in_data0});
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        #1;
        checks++;
        if (out_valid1 !== 1'b0 || occ1 !== 2'd0 || in_ready1 !== 1'b1 || out_ctrl1 !== '0) begin
            errors++;
            $display("FAIL reset_skid got valid=%0b occ=%0d ready=%0b ctrl=%0h expected 0 0 1 0",
                     out_valid1, occ1, in_ready1, out_ctrl1);
        end
        checks++;
        if (out_valid0 !== 1'b0 || occ0 !== 2'd0 || in_ready0 !== 1'b1 || out_ctrl0 !== '0) begin
            errors++;
            $display("FAIL reset_single got valid=%0b occ=%0d ready=%0b ctrl=%0h expected 0 0 1 0",
                     out_valid0, occ0, in_ready0, out_ctrl0);
        end
        step();
    endtask

    task automatic test_stream();
        in_valid1 = 1'b1;
        in_ctrl1 = 5'b10101;
        out_ready1 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            in_data1 = k + 1;
            #1;
            checks++;
            if (out_valid1 !== (k > 0)) begin
                errors++;
                $display("FAIL stream_out_valid cycle=%0d got %0b expected %0b", k, out_valid1, (k > 0));
            end
            checks++;
            if (in_ready1 !== 1'b1) begin
                errors++;
                $display("FAIL stream_in_ready cycle=%0d got %0b expected 1", k, in_ready1);
            end
            if (k > 0) begin
                checks++;
                if (occ1 !== 2'd1) begin
                    errors++;
                    $display("FAIL stream_occupancy cycle=%0d got %0d expected 1", k, occ1);
                end
            end
            step();
        end
        in_valid1 = 1'b0;
        repeat (2) begin #1; step(); end
        checks++;
        if (sb1.size() != 0) begin
            errors++;
            $display("FAIL stream_drain got %0d pending expected 0", sb1.size());
        end
    endtask

    task automatic test_backpressure();
        in_valid1 = 1'b1; in_data1 = 10; in_ctrl1 = 5'd10; out_ready1 = 1'b1;
        #1; step();
        in_data1 = 11; in_ctrl1 = 5'd11; out_ready1 = 1'b0;
        #1;
        checks++;
        if (out_valid1 !== 1'b1 || out_data1 !== 32'd10) begin
            errors++;
            $display("FAIL bp_head got valid=%0b data=%0d expected 1 10", out_valid1, out_data1);
        end
        step();
        in_data1 = 12; in_ctrl1 = 5'd12;
        #1;
        checks++;
        if (occ1 !== 2'd2 || in_ready1 !== 1'b0) begin
            errors++;
            $display("FAIL bp_full got occ=%0d ready=%0b expected 2 0", occ1, in_ready1);
        end
        step();
        #1;
        checks++;
        if (in_ready1 !== 1'b0 || out_data1 !== 32'd10) begin
            errors++;
            $display("FAIL bp_hold got ready=%0b data=%0d expected 0 10", in_ready1, out_data1);
        end
        step();
        out_ready1 = 1'b1;
        #1; step();
        #1;
        checks++;
        if (in_ready1 !== 1'b1 || out_data1 !== 32'd11) begin
            errors++;
            $display("FAIL bp_release got ready=%0b data=%0d expected 1 11", in_ready1, out_data1);
        end
        step();
        in_valid1 = 1'b0;
        repeat (2) begin #1; step(); end
        checks++;
        if (sb1.size() != 0 || occ1 !== 2'd0) begin
            errors++;
            $display("FAIL bp_drain got pending=%0d occ=%0d expected 0 0", sb1.size(), occ1);
        end
    endtask

    task automatic test_bubble();
        in_valid1 = 1'b0; in_ctrl1 = 5'h1F; in_data1 = 32'hDEAD_BEEF; out_ready1 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (out_valid1 !== 1'b0 || out_ctrl1 !== '0) begin
                errors++;
                $display("FAIL bubble got valid=%0b ctrl=%0h expected 0 0", out_valid1, out_ctrl1);
            end
            step();
        end
    endtask

    task automatic test_flush();
        out_ready1 = 1'b0; in_valid1 = 1'b1;
        in_data1 = 20; in_ctrl1 = 5'h14; #1; step();
        in_data1 = 21; in_ctrl1 = 5'h15; #1; step();
        in_data1 = 22; in_ctrl1 = 5'h16; flush = 1'b1;
        #1; step();
        flush = 1'b0; in_valid1 = 1'b0; out_ready1 = 1'b1;
        #1;
        checks++;
        if (occ1 !== 2'd0 || out_valid1 !== 1'b0 || out_ctrl1 !== '0 || in_ready1 !== 1'b1) begin
            errors++;
            $display("FAIL flush_two got occ=%0d valid=%0b ctrl=%0h ready=%0b expected 0 0 0 1",
                     occ1, out_valid1, out_ctrl1, in_ready1);
        end
        repeat (3) begin step(); #1; end
        // Flush in ONE: head issues in the flush cycle, the new beat is dropped.
        in_valid1 = 1'b1; in_data1 = 50; in_ctrl1 = 5'h1A;
        step();
        in_data1 = 51; in_ctrl1 = 5'h1B; flush = 1'b1;
        #1; step();
        flush = 1'b0; in_valid1 = 1'b0;
        #1;
        checks++;
        if (occ1 !== 2'd0 || out_valid1 !== 1'b0) begin
            errors++;
            $display("FAIL flush_one got occ=%0d valid=%0b expected 0 0", occ1, out_valid1);
        end
        repeat (3) begin step(); #1; end
    endtask

    task automatic test_skid0();
        int nxt;
        logic acc;
        nxt = 30;
        in_valid0 = 1'b1;
        for (int k = 0; k < 10; k++) begin
            out_ready0 = (k % 2 == 0);
            in_data0 = nxt;
            in_ctrl0 = nxt[4:0];
            #1;
            checks++;
            if (in_ready0 !== (~out_valid0 | out_ready0)) begin
                errors++;
                $display("FAIL single_in_ready cycle=%0d got %0b expected %0b", k, in_ready0, ~out_valid0 | out_ready0);
            end
            acc = in_valid0 & in_ready0;
            step();
            if (acc) nxt++;
        end
        in_valid0 = 1'b0; out_ready0 = 1'b1;
        repeat (3) begin #1; step(); end
        checks++;
        if (sb0.size() != 0 || nxt != 35) begin
            errors++;
            $display("FAIL single_drain got pending=%0d next=%0d expected 0 35", sb0.size(), nxt);
        end
        out_ready0 = 1'b0;
    endtask

    task automatic test_reset_mid();
        out_ready1 = 1'b0; in_valid1 = 1'b1;
        in_data1 = 40; in_ctrl1 = 5'h08; #1; step();
        in_data1 = 41; in_ctrl1 = 5'h09; #1; step();
        in_valid1 = 1'b0;
        #1;
        checks++;
        if (occ1 !== 2'd2) begin
            errors++;
            $display("FAIL rmid_fill got occ=%0d expected 2", occ1);
        end
        reset = 1'b1; flush = 1'b1;
        step();
        reset = 1'b0; flush = 1'b0;
        #1;
        checks++;
        if (occ1 !== 2'd0 || out_valid1 !== 1'b0 || in_ready1 !== 1'b1 || out_ctrl1 !== '0) begin
            errors++;
            $display("FAIL rmid got occ=%0d valid=%0b ready=%0b ctrl=%0h expected 0 0 1 0",
                     occ1, out_valid1, in_ready1, out_ctrl1);
        end
        out_ready1 = 1'b1;
        repeat (3) begin step(); #1; end
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0;
        in_valid1 = 1'b0; in_ctrl1 = '0; in_data1 = '0; out_ready1 = 1'b0;
        in_valid0 = 1'b0; in_ctrl0 = '0; in_data0 = '0; out_ready0 = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_bubble();
        test_flush();
        test_skid0();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
